// File: rtl/conv_pool_stage.sv
// Max-pooling stage behind the 5-tap int8 conv element: re-derives sample validity from delayed
// source flags, masks warm-up windows and emits pooled samples. Optional ReLU clamp: RELU_EN.
module conv_pool_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 5,
  parameter int CONV_LAT   = 5,
  parameter int POOL       = 2,
  parameter int IDX_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       src_valid,
  input  logic                       src_sof,
  input  logic                       src_eof,
  input  logic [DATA_WIDTH-1:0]      conv_in,
  output logic [DATA_WIDTH-1:0]      pool_out,
  output logic                       pool_valid,
  output logic                       pool_eof,
  output logic [IDX_W-1:0]           pool_idx,
  output logic [$clog2(POOL+1)-1:0]  dbg_pcnt_o
);

  localparam int WCNT_W = $clog2(TAPS + 1);
  localparam int PCNT_W = $clog2(POOL + 1);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  // Input side: warm-up counter and flag delay line aligned to conv_in.
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              win_ok;
  logic [2:0]        dly_q [CONV_LAT];
  logic              d_ok, d_sof, d_eof;

  always_comb begin
    wcnt_d = '0;
    if (src_valid && src_sof) begin
      wcnt_d = WCNT_W'(1);
    end else if (src_valid) begin
      wcnt_d = (wcnt_q == WCNT_W'(TAPS)) ? wcnt_q : wcnt_q + WCNT_W'(1);
    end
    win_ok = src_valid && (wcnt_d == WCNT_W'(TAPS));
  end

  assign {d_ok, d_sof, d_eof} = dly_q[CONV_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      for (int i = 0; i < CONV_LAT; i++) dly_q[i] <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      dly_q[0] <= {win_ok, src_valid & src_sof, src_valid & src_eof};
      for (int i = 1; i < CONV_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Pool FSM state: group position, running max, frame index and registered outputs.
  logic              armed_q, armed_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  sample_t           acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  sample_t           out_q, out_d;
  logic              valid_q, valid_d;
  logic              eof_q, eof_d;
  logic [IDX_W-1:0]  oidx_q, oidx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      pcnt_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      oidx_q  <= '0;
    end else begin
      armed_q <= armed_d;
      pcnt_q  <= pcnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
      oidx_q  <= oidx_d;
    end
  end

  logic              ok_eff, group_done, emit;
  logic [PCNT_W-1:0] pcnt_base, pcnt_new;
  logic [IDX_W-1:0]  idx_base;
  sample_t           acc_base, acc_new, v;

  always_comb begin
    // A frame start clears prior-frame state before this cycle's sample is folded in;
    // samples are ignored until the first SOF after reset.
    armed_d   = armed_q | d_sof;
    ok_eff    = d_ok & armed_d;
    pcnt_base = d_sof ? '0 : pcnt_q;
    idx_base  = d_sof ? '0 : idx_q;
    acc_base  = d_sof ? '0 : acc_q;

    v = sample_t'(conv_in);
`ifdef RELU_EN
    if (v < 0) v = '0;
`endif

    acc_new  = acc_base;
    pcnt_new = pcnt_base;
    if (ok_eff) begin
      if (pcnt_base == '0 || v > acc_base) acc_new = v;
      pcnt_new = pcnt_base + PCNT_W'(1);
    end

    group_done = ok_eff && (pcnt_new == PCNT_W'(POOL));
    emit       = group_done || (d_eof && armed_d && pcnt_new != '0);

    acc_d   = acc_new;
    pcnt_d  = group_done ? '0 : pcnt_new;
    idx_d   = emit ? idx_base + IDX_W'(1) : idx_base;
    valid_d = emit;
    eof_d   = emit && d_eof;
    out_d   = emit ? acc_new : out_q;
    oidx_d  = emit ? idx_base : oidx_q;
    if (d_eof) begin
      pcnt_d = '0;
      idx_d  = '0;
    end
  end

  always_comb begin
    pool_out   = out_q;
    pool_valid = valid_q;
    pool_eof   = eof_q;
    pool_idx   = oidx_q;
    dbg_pcnt_o = pcnt_q;
  end

endmodule

// File: tb/tb_conv_pool_stage.sv
// Directed bench for conv_pool_stage: per-frame stimulus tables, observed pulses vs expected queue.
module tb_conv_pool_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       src_valid, src_sof, src_eof;
  logic [7:0] conv_in;
  logic [7:0] pool_out;
  logic       pool_valid, pool_eof;
  logic [7:0] pool_idx;
  logic [1:0] dbg_pcnt;

  int n_cmp = 0;
  int n_bad = 0;

  conv_pool_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_sof    (src_sof),
    .src_eof    (src_eof),
    .conv_in    (conv_in),
    .pool_out   (pool_out),
    .pool_valid (pool_valid),
    .pool_eof   (pool_eof),
    .pool_idx   (pool_idx),
    .dbg_pcnt_o (dbg_pcnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Frame stimulus tables, indexed by cycle from the first src_valid.
  logic       fv [64];
  logic       fs [64];
  logic       fe [64];
  logic [7:0] fc [64];

  // Observed/expected pulses packed as {cycle, idx, eof, out}.
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [7:0] rl(input logic [7:0] x);
`ifdef RELU_EN
    return x[7] ? 8'd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [24:0] pk(input int cyc, input int idx, input logic eof, input logic [7:0] o);
    return {8'(cyc), 8'(idx), eof, o};
  endfunction

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 254)) - 8'd127;
  endfunction

  task automatic new_frame(input int len);
    for (int k = 0; k < 64; k++) begin
      fv[k] = 1'b0;
      fs[k] = 1'b0;
      fe[k] = 1'b0;
      fc[k] = rnd8();
    end
    for (int k = 0; k < len; k++) fv[k] = 1'b1;
    fs[0]     = 1'b1;
    fe[len-1] = 1'b1;
  endtask

  // Driver: starts just after a rising edge, samples outputs on the falling edge.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      src_valid = fv[k];
      src_sof   = fs[k];
      src_eof   = fe[k];
      conv_in   = fc[k];
      @(negedge clk);
      if (pool_valid) obs_q.push_back({8'(k), pool_idx, pool_eof, pool_out});
      @(posedge clk);
      #1;
    end
    src_valid = 1'b0;
    src_sof   = 1'b0;
    src_eof   = 1'b0;
  endtask

  // Scoreboard
  task automatic check_frame(input string name);
    logic [24:0] e, o;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s pulse count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_bad++;
        $display("FAIL %s[%0d]: got no pulse, want cyc=%0d idx=%0d eof=%0b out=%0d",
                 name, i, e[24:17], e[16:9], e[8], $signed(e[7:0]));
      end else begin
        o = obs_q[i];
        if (o !== e) begin
          n_bad++;
          $display("FAIL %s[%0d]: got cyc=%0d idx=%0d eof=%0b out=%0d, want cyc=%0d idx=%0d eof=%0b out=%0d",
                   name, i, o[24:17], o[16:9], o[8], $signed(o[7:0]),
                   e[24:17], e[16:9], e[8], $signed(e[7:0]));
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    vecs[0] = '{"mixed_sign",  8'(-5),   8'(3),    8'(3)};
    vecs[1] = '{"both_neg",    8'(-100), 8'(-7),   rl(8'(-7))};
    vecs[2] = '{"extremes",    8'(127),  8'(-127), 8'(127)};
    vecs[3] = '{"min_both",    8'(-127), 8'(-127), rl(8'(-127))};
    vecs[4] = '{"equal_pos",   8'(7),    8'(7),    8'(7)};
    vecs[5] = '{"first_wins",  8'(3),    8'(-5),   8'(3)};

    // Reset held while inputs toggle randomly: outputs stay zero.
    rst_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      src_valid = 1'($urandom_range(0, 1));
      src_sof   = 1'($urandom_range(0, 1));
      src_eof   = 1'($urandom_range(0, 1));
      conv_in   = rnd8();
      @(negedge clk);
      n_cmp++;
      if ({pool_valid, pool_eof, pool_out, pool_idx, dbg_pcnt} !== '0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got valid=%0b eof=%0b out=%0d idx=%0d pcnt=%0d, want all 0",
                 k, pool_valid, pool_eof, $signed(pool_out), pool_idx, dbg_pcnt);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_valid = 1'b0; src_sof = 1'b0; src_eof = 1'b0;
    @(posedge clk);
    #1;

    // 10 contiguous samples: d_ok at cycles 9..14.
    new_frame(10);
    fc[9] = 8'(10);  fc[10] = 8'(20);
    fc[11] = 8'(-30); fc[12] = 8'(5);
    fc[13] = 8'(50);  fc[14] = 8'(-60);
    exp_q.push_back(pk(11, 0, 1'b0, 8'(20)));
    exp_q.push_back(pk(13, 1, 1'b0, 8'(5)));
    exp_q.push_back(pk(15, 2, 1'b1, 8'(50)));
    run_cycles(30);
    check_frame("frame10");

    // Table: 6-sample frames give exactly one group from d_ok at cycles 9 and 10.
    for (int i = 0; i < 6; i++) begin
      new_frame(6);
      fc[9]  = vecs[i].a;
      fc[10] = vecs[i].b;
      exp_q.push_back(pk(11, 0, 1'b1, vecs[i].exp));
      run_cycles(24);
      check_frame(vecs[i].name);
    end

    // 11 samples -> 7 windows; last is a single-window partial flushed by EOF.
    new_frame(11);
    for (int k = 0; k < 6; k++) fc[9+k] = 8'(k + 1);
    fc[15] = 8'(-9);
    exp_q.push_back(pk(11, 0, 1'b0, 8'(2)));
    exp_q.push_back(pk(13, 1, 1'b0, 8'(4)));
    exp_q.push_back(pk(15, 2, 1'b0, 8'(6)));
    exp_q.push_back(pk(16, 3, 1'b1, rl(8'(-9))));
    run_cycles(30);
    check_frame("frame11_partial");

    // Gap at cycle 7: windows at 4,5,6 and 12,13; third window's group spans the gap.
    new_frame(14);
    fv[7] = 1'b0;
    fc[9] = 8'(-1); fc[10] = 8'(-2); fc[11] = 8'(40);
    fc[17] = 8'(41); fc[18] = 8'(-50);
    exp_q.push_back(pk(11, 0, 1'b0, rl(8'(-1))));
    exp_q.push_back(pk(18, 1, 1'b0, 8'(41)));
    exp_q.push_back(pk(19, 2, 1'b1, rl(8'(-50))));
    run_cycles(34);
    check_frame("gap_hold");

    // Reset mid-frame: first group emerges, then reset drops the pending half group.
    new_frame(10);
    fc[9] = 8'(11); fc[10] = 8'(12); fc[11] = 8'(99);
    exp_q.push_back(pk(11, 0, 1'b0, 8'(12)));
    run_cycles(12);
    check_frame("pre_reset");
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      conv_in   = rnd8();
      src_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    // Rest of the old frame without SOF must produce nothing.
    new_frame(8);
    fs[0] = 1'b0;
    run_cycles(24);
    check_frame("no_sof_after_reset");
    new_frame(6);
    fc[9] = 8'(33); fc[10] = 8'(-33);
    exp_q.push_back(pk(11, 0, 1'b1, 8'(33)));
    run_cycles(24);
    check_frame("fresh_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
